// File: rtl/mem_dump_unit.sv
// Memory read-back engine: walks a latched address range and streams each byte with its address over valid/ready.
// Optional macro DUMP_CHECKSUM_EN appends a modular-sum beat after the last memory beat.
module mem_dump_unit #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Dump,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              valid,
  input  logic              ready,
  output logic              last,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_FIN     = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_stop;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_data_out;
  logic [ADDR_W-1:0] r_addr_out;
  logic              r_valid;
  logic              r_last;
  logic              r_busy;
  logic              r_done;
  logic              w_at_stop;

  assign w_at_stop = (r_ptr == r_stop);

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic              r_csum_beat;

  // Running sum of presented bytes and the flag marking the trailing checksum beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sum       <= '0;
      r_csum_beat <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sum       <= '0;
          r_csum_beat <= 1'b0;
        end
        S_WAIT: begin
          r_sum <= r_sum + mem_data;
        end
        S_PRESENT: begin
          if (ready && !r_csum_beat && w_at_stop) begin
            r_csum_beat <= 1'b1;
          end
        end
        default: begin
          r_sum <= r_sum;
        end
      endcase
    end
  end
`endif

  // Dump sequencer: one read pulse per address, output beat held until accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_stop     <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_data_out <= '0;
      r_addr_out <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (Dump) begin
            r_ptr      <= start_addr;
            r_stop     <= end_addr;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= start_addr;
            r_busy     <= 1'b1;
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          r_mem_rd <= 1'b0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          r_data_out <= mem_data;
          r_addr_out <= r_ptr;
          r_valid    <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
          r_last     <= 1'b0;
`else
          r_last     <= w_at_stop;
`endif
          r_state    <= S_PRESENT;
        end
        S_PRESENT: begin
          if (ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            if (r_csum_beat) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else if (w_at_stop) begin
              // Trailing checksum beat follows immediately; the sum already includes this byte.
              r_valid    <= 1'b1;
              r_data_out <= r_sum;
              r_addr_out <= '0;
              r_last     <= 1'b1;
            end else begin
              r_ptr      <= r_ptr + 1'b1;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= r_ptr + 1'b1;
              r_state    <= S_READ;
            end
`else
            if (w_at_stop) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_ptr      <= r_ptr + 1'b1;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= r_ptr + 1'b1;
              r_state    <= S_READ;
            end
`endif
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign data_out = r_data_out;
  assign addr_out = r_addr_out;
  assign valid    = r_valid;
  assign last     = r_last;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
